// File: rtl/audio_mix_pkg.sv
// Shared voice-mode encoding and saturation helpers for the tone mixer.
package audio_mix_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_SQUARE = 2'b01,
    MODE_PULSE  = 2'b10,
    MODE_RSVD   = 2'b11
  } voice_mode_e;

  localparam int unsigned DEFAULT_AMP = 10000000;

  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/audio_tone_voice.sv
// One tone voice: half-period counter, 2-bit phase and square/pulse level.
module audio_tone_voice
  import audio_mix_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIV_W  = 19,
  parameter int unsigned AMP    = DEFAULT_AMP
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic [1:0]               mode,
  input  logic [DIV_W-1:0]         period,
  output logic signed [DATA_W-1:0] level
);

  localparam logic signed [DATA_W-1:0] AmpS = DATA_W'(AMP);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic             enabled;
  logic             high;

  always_comb begin
    enabled = (mode == MODE_SQUARE) || (mode == MODE_PULSE);
    cnt_d   = cnt_q + DIV_W'(1);
    phase_d = phase_q;
    if (!enabled) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (cnt_q >= period) begin
      // >= so a period lowered below the running count wraps next clock
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end
  end

  always_comb begin
    high  = (mode == MODE_SQUARE) ? !phase_q[0] : (phase_q == 2'd0);
    level = '0;
    if (enabled) level = high ? AmpS : -AmpS;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/audio_tone_mixer.sv
// Multi-voice tone generator with saturating stereo mix into a one-entry
// valid/ready output register.
module audio_tone_mixer
  import audio_mix_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned DIV_W      = 19,
  parameter int unsigned AMP        = DEFAULT_AMP
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic [2*NUM_VOICES-1:0]       voice_mode,
  input  logic [DIV_W*NUM_VOICES-1:0]   voice_period,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_W-1:0]      in_left,
  input  logic signed [DATA_W-1:0]      in_right,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_W-1:0]      out_left,
  output logic signed [DATA_W-1:0]      out_right
);

  localparam int unsigned SUM_W = DATA_W + 4;
  localparam logic signed [SUM_W-1:0] SatHi = SUM_W'(sat_max(DATA_W));
  localparam logic signed [SUM_W-1:0] SatLo = SUM_W'(sat_min(DATA_W));

  logic signed [DATA_W-1:0] level [NUM_VOICES];
  logic signed [SUM_W-1:0]  voice_sum, sum_left, sum_right;
  logic                     accept;
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_left_q, out_right_q;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    audio_tone_voice #(
      .DATA_W (DATA_W),
      .DIV_W  (DIV_W),
      .AMP    (AMP)
    ) u_voice (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .mode     (voice_mode[2*i +: 2]),
      .period   (voice_period[i*DIV_W +: DIV_W]),
      .level    (level[i])
    );
  end

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
    if (v > SatHi) return SatHi[DATA_W-1:0];
    if (v < SatLo) return SatLo[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  always_comb begin
    voice_sum = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_sum = voice_sum + SUM_W'(level[i]);
    end
    sum_left  = SUM_W'(in_left) + voice_sum;
    sum_right = SUM_W'(in_right) + voice_sum;
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_left_q  <= saturate(sum_left);
      out_right_q <= saturate(sum_right);
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_left  = out_left_q;
  assign out_right = out_right_q;

endmodule

// File: doc/audio_tone_mixer.md
# audio_tone_mixer

Parametrised multi-voice tone generator and saturating mixer that sits between the audio controller's input FIFO side and its output FIFO side. Up to NUM_VOICES independent square/pulse tone voices, each with its own period and mode, are added to the incoming left/right samples with signed saturation. Samples move through a one-entry valid/ready output register, so the controller's read and write strobes are derived from the handshake rather than from a single combined condition.

## Interface
- DATA_W, 32: signed sample width per channel
- NUM_VOICES, 4: number of tone voices (1..8)
- DIV_W, 19: width of each voice's half-period divider
- AMP, 10000000: voice amplitude magnitude; must fit in DATA_W-1 bits
- CLOCK_50  in  1  sole clock; all state on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- voice_mode  in  2*NUM_VOICES  per voice: 00 off, 01 square, 10 pulse 25 %, 11 reserved (treated as off)
- voice_period  in  DIV_W*NUM_VOICES  per-voice terminal count; voice i at bits [i*DIV_W +: DIV_W]
- in_valid  in  1  input sample pair available
- in_ready  out  1  block accepts the input pair this cycle
- in_left, in_right  in  DATA_W each  signed input samples
- out_valid  out  1  mixed pair held in the output register
- out_ready  in  1  downstream consumes the output pair this cycle
- out_left, out_right  out  DATA_W each  signed mixed samples

## Operation
- Voice counter cnt[i] (DIV_W bits) increments every clock; terminal when cnt[i] >= voice_period[i]; on terminal cnt[i] <= 0 and phase[i] (2 bits) increments modulo 4.
- Period 0: terminal every clock. Period lowered below current cnt: terminal on the next clock (>= compare), no wrap through 2^DIV_W.
- Level: square = +AMP when phase[0]==0 else -AMP (full cycle 2*(period+1) clocks); pulse = +AMP when phase==0 else -AMP (cycle 4*(period+1) clocks, 25 % duty); off/reserved = 0.
- Mode off or reserved: cnt and phase forced to 0 each clock; re-enabling starts at phase 0, +AMP.
- Mode change between square and pulse: counter and phase continue without reset.
- Mix: sum = in + Σ level[i], computed signed in DATA_W+4 bits, both channels get the same voice sum; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Handshake: in_ready = !out_valid || out_ready (combinational). Accept when in_valid && in_ready: output register loads the saturated mix using the voice levels of the current cycle, and out_valid <= 1. Else if out_ready: out_valid <= 0.
- Simultaneous accept and consume: register reloads, out_valid stays 1, no bubble.
- While out_valid && !out_ready: out_left/out_right held stable, in_ready = 0.

## Timing
- Reset (async assert, sync release acceptable): cnt = 0, phase = 0, out_valid = 0, out_left = out_right = 0; in_ready = 1 after reset.
- Latency: input accepted in cycle N appears on out_* with out_valid = 1 in cycle N+1.
- Throughput: one pair per clock when out_ready held high.
- Reset mid-operation: out_valid drops to 0 immediately on reset_n low; any held pair is discarded.
- Voice level changes one clock after the terminal count edge.

## Structure
- Package audio_mix_pkg: voice-mode constants (MODE_OFF, MODE_SQUARE, MODE_PULSE), default AMP, helper for saturation bounds.
- Sub-module audio_tone_voice: one counter/phase/level generator, instantiated NUM_VOICES times by generate loop; mixer, saturation and output register stay in the top.
- Top-level board wrapper drives read/write of the audio controller from in_valid && in_ready and out_valid && out_ready.

## Test plan
- Reset: hold reset_n low with in_valid = 1 -> out_valid = 0, outputs 0; after release in_ready = 1.
- Voice 0 square, period 3, others off, in = 0, in_valid and out_ready high -> out_left = +10000000 for 4 samples, then -10000000 for 4, repeating.
- Voice 0 pulse, period 1 -> +10000000 for 2 samples, -10000000 for 6, repeating; switch to off -> 0 next sample, re-enable restarts at +AMP.
- Saturation: in_left = 0x7FFF0000, all 4 voices at +AMP -> out_left = 0x7FFFFFFF; in_right = 0x80010000, all at -AMP -> out_right = 0x80000000.
- Backpressure: out_ready low 3 cycles with out_valid high -> out_* stable, in_ready = 0; out_ready high with in_valid high -> new pair next cycle, no bubble.
- Period drop: voice running period 1000 at cnt 500, write period 100 -> terminal next clock, then 101-clock half-periods.
